// File: rtl/vend_ctrl_multi.sv
// Multi-channel vending controller: coin credit with saturation, per-channel price and stock,
// edge-detected front-panel buttons, one-cycle vend / payout / reject / fail pulses.
module vend_ctrl_multi #(
    parameter int N_PROD     = 6,
    parameter int MONEY_W    = 8,
    parameter int STOCK_W    = 3,
    parameter int STOCK_MAX  = 7,
    parameter int CREDIT_MAX = 255,
    parameter logic [N_PROD*MONEY_W-1:0] PRICES = {8'd40, 8'd35, 8'd30, 8'd25, 8'd20, 8'd15}
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [MONEY_W-1:0]          coin_i,
    input  logic                        coin_valid_i,
    input  logic                        change_btn_i,
    input  logic [N_PROD-1:0]           sel_btn_i,
    input  logic                        restock_i,
    output logic [N_PROD-1:0]           led_o,
    output logic [N_PROD-1:0]           sold_out_o,
    output logic [MONEY_W-1:0]          credit_o,
    output logic [N_PROD*STOCK_W-1:0]   stock_o,
    output logic [N_PROD-1:0]           vend_o,
    output logic [MONEY_W-1:0]          change_o,
    output logic                        change_valid_o,
    output logic                        reject_o,
    output logic                        fail_o,
    output logic [1:0]                  state_dbg_o
);

    localparam int IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_MAX);
    localparam logic [MONEY_W:0]   CREDIT_CAP = (MONEY_W+1)'(CREDIT_MAX);

    // Debug encoding: 0 IDLE, 1 CREDIT, 2 VEND, 3 PAYOUT.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_PAYOUT = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [MONEY_W-1:0]          credit_q, credit_d;
    logic [N_PROD*STOCK_W-1:0]   stock_q, stock_d;
    logic [N_PROD-1:0]           vend_q, vend_d;
    logic [MONEY_W-1:0]          change_q, change_d;
    logic                        change_valid_q, change_valid_d;
    logic                        reject_q, reject_d;
    logic                        fail_q, fail_d;
    logic [N_PROD-1:0]           sel_prev;
    logic                        change_prev, restock_prev;

    logic [N_PROD-1:0]           sel_edge;
    logic                        change_edge, restock_edge, sel_any, sel_found, acted;
    logic [IDX_W-1:0]            sel_idx;
    logic [MONEY_W-1:0]          sel_price;
    logic [STOCK_W-1:0]          sel_stock;
    logic [MONEY_W:0]            coin_sum;

    assign sel_edge     = sel_btn_i & ~sel_prev;
    assign change_edge  = change_btn_i & ~change_prev;
    assign restock_edge = restock_i & ~restock_prev;
    assign sel_any      = |sel_edge;
    assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_i};

    // Several simultaneous select edges: the lowest channel index wins.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < N_PROD; i++) begin
            if (sel_edge[i] && !sel_found) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign sel_price = PRICES[sel_idx*MONEY_W +: MONEY_W];
    assign sel_stock = stock_q[sel_idx*STOCK_W +: STOCK_W];

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        stock_d        = stock_q;
        vend_d         = '0;
        change_d       = '0;
        change_valid_d = 1'b0;
        reject_d       = 1'b0;
        fail_d         = 1'b0;
        acted          = 1'b0;
        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (change_edge && credit_q != '0) begin
                    state_d        = S_PAYOUT;
                    change_d       = credit_q;
                    change_valid_d = 1'b1;
                    credit_d       = '0;
                    fail_d         = sel_any;
                    acted          = 1'b1;
                end else if (sel_any) begin
                    if (sel_stock != '0 && credit_q >= sel_price) begin
                        state_d  = S_VEND;
                        credit_d = credit_q - sel_price;
                        stock_d[sel_idx*STOCK_W +: STOCK_W] = sel_stock - STOCK_W'(1);
                        vend_d[sel_idx] = 1'b1;
                        acted    = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                    end
                end
                // A coin is only credited when nothing of higher priority acted this cycle.
                if (coin_valid_i) begin
                    if (acted || coin_sum > CREDIT_CAP) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[MONEY_W-1:0];
                    end
                end
                if (!acted) begin
                    state_d = (credit_d != '0) ? S_CREDIT : S_IDLE;
                end
            end
            S_VEND: begin
                reject_d = coin_valid_i;
                fail_d   = sel_any;
                state_d  = (credit_q != '0) ? S_CREDIT : S_IDLE;
            end
            default: begin
                reject_d = coin_valid_i;
                fail_d   = sel_any;
                state_d  = S_IDLE;
            end
        endcase
        if (restock_edge) begin
            stock_d = {N_PROD{STOCK_FULL}};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            stock_q        <= {N_PROD{STOCK_FULL}};
            vend_q         <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            reject_q       <= 1'b0;
            fail_q         <= 1'b0;
            sel_prev       <= '0;
            change_prev    <= 1'b0;
            restock_prev   <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            stock_q        <= stock_d;
            vend_q         <= vend_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            reject_q       <= reject_d;
            fail_q         <= fail_d;
            sel_prev       <= sel_btn_i;
            change_prev    <= change_btn_i;
            restock_prev   <= restock_i;
        end
    end

    always_comb begin
        for (int i = 0; i < N_PROD; i++) begin
            sold_out_o[i] = (stock_q[i*STOCK_W +: STOCK_W] == '0);
            led_o[i]      = (stock_q[i*STOCK_W +: STOCK_W] != '0) &&
                            (credit_q >= PRICES[i*MONEY_W +: MONEY_W]);
        end
    end

    assign credit_o       = credit_q;
    assign stock_o        = stock_q;
    assign vend_o         = vend_q;
    assign change_o       = change_q;
    assign change_valid_o = change_valid_q;
    assign reject_o       = reject_q;
    assign fail_o         = fail_q;
    assign state_dbg_o    = state_q;

endmodule
